// File: rtl/rx_dig_sequencer_pkg.sv
// Purpose : shared settings-register address, control-word layout and FSM encoding for rx_dig_sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package rx_dig_sequencer_pkg;

    // Serial settings addresses (kept together so address clashes are easy to spot).
    localparam logic [6:0] RX_DIG_SEQ_ADDR = 7'd40;

    // Control-word bit positions.
    localparam int CTL_I_SEL_LSB    = 0;
    localparam int CTL_Q_SEL_LSB    = 4;
    localparam int CTL_GO_BIT       = 8;
    localparam int CTL_TRIG_EN_BIT  = 9;
    localparam int CTL_TRIG_SEL_LSB = 10;
    localparam int CTL_STICKY_BIT   = 14;
    localparam int CTL_BURST_LSB    = 16;

    // Packed view of the 32-bit control word; field order matches the positions above.
    typedef struct packed {
        logic [15:0] burst_len;   // 0 = continuous
        logic        rsvd;
        logic        sticky;
        logic [3:0]  trig_sel;
        logic        trig_en;
        logic        go;
        logic [3:0]  q_sel;
        logic [3:0]  i_sel;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rx_dig_sequencer_gpio_sync.sv
// Purpose : SYNC_STG-deep flop chain bringing asynchronous GPIO pins into the clock domain.
// Latency : SYNC_STG cycles, pin to gpio_o.
// Backpressure: none, free-running every cycle.
// Ports   : clk_i, rst_i (sync, active-high), gpio_i (async pins), gpio_o (synchronised pins).
module rx_dig_sequencer_gpio_sync #(
    parameter int GPIO_W   = 16,
    parameter int SYNC_STG = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o
);

    logic [GPIO_W-1:0] stg_q [SYNC_STG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < SYNC_STG; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            stg_q[0] <= gpio_i;
            for (int k = 1; k < SYNC_STG; k++) begin
                stg_q[k] <= stg_q[k-1];
            end
        end
    end

    assign gpio_o = stg_q[SYNC_STG-1];

endmodule

// File: rtl/rx_dig_sequencer.sv
// Purpose : arms/gates GPIO digital capture into rx_chain_dig; picks I/Q bits, optional sticky-OR, trigger, burst.
// Latency : pin -> i_dig/q_dig = SYNC_STG cycles + wait to next sample_strobe + 1 cycle.
// Backpressure: none; outputs update only on sample_strobe (abort and reset excepted).
// Ports   : clock, reset (sync, active-high); serial_strobe/addr/data settings bus; sample_strobe;
//           gpio_in async pins; dig_enable/i_dig/q_dig to rx_chain_dig; busy (ARMED|RUN), done (DONE).
module rx_dig_sequencer
    import rx_dig_sequencer_pkg::*;
#(
    parameter logic [6:0] ADDR     = RX_DIG_SEQ_ADDR,
    parameter int         GPIO_W   = 16,
    parameter int         SYNC_STG = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_strobe,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              sample_strobe,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              dig_enable,
    output logic              i_dig,
    output logic              q_dig,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------
    // Settings decode
    // ------------------------------------------------------------------
    ctrl_t wr_dat;
    logic  wr_hit;
    logic  start;
    logic  abort;
    logic  unused_rsvd;

    assign wr_dat      = ctrl_t'(serial_data);
    assign wr_hit      = serial_strobe && (serial_addr == ADDR);
    assign unused_rsvd = wr_dat.rsvd;

    seq_state_e state_q, state_d;

    // go=1 only starts a capture from IDLE/DONE; while ARMED/RUN it is a live settings update.
    assign start = wr_hit && wr_dat.go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign abort = wr_hit && !wr_dat.go;

    // Live fields: take effect on any write.
    logic [3:0] i_sel_q, q_sel_q;
    logic       sticky_q;
    // Start-time fields: captured only when a capture is started.
    logic [3:0]  trig_sel_q;
    logic        trig_en_q;
    logic [15:0] burst_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            i_sel_q    <= '0;
            q_sel_q    <= '0;
            sticky_q   <= 1'b0;
            trig_sel_q <= '0;
            trig_en_q  <= 1'b0;
            burst_q    <= '0;
        end else begin
            if (wr_hit) begin
                i_sel_q  <= wr_dat.i_sel;
                q_sel_q  <= wr_dat.q_sel;
                sticky_q <= wr_dat.sticky;
            end
            if (start) begin
                trig_sel_q <= wr_dat.trig_sel;
                trig_en_q  <= wr_dat.trig_en;
                burst_q    <= wr_dat.burst_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // GPIO synchronisation and bit selection
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] g_sync;

    rx_dig_sequencer_gpio_sync #(
        .GPIO_W   (GPIO_W),
        .SYNC_STG (SYNC_STG)
    ) u_gpio_sync (
        .clk_i  (clock),
        .rst_i  (reset),
        .gpio_i (gpio_in),
        .gpio_o (g_sync)
    );

    logic gi, gq, gt;
    logic gt_prev_q;
    logic trig_rise;

    assign gi        = g_sync[i_sel_q];
    assign gq        = g_sync[q_sel_q];
    assign gt        = g_sync[trig_sel_q];
    assign trig_rise = trig_en_q && gt && !gt_prev_q;

    // ------------------------------------------------------------------
    // Accumulators and strobe-aligned dig outputs
    // ------------------------------------------------------------------
    logic acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic i_dig_q, i_dig_d, q_dig_q, q_dig_d;

    always_comb begin
        acc_i_d = gi;
        acc_q_d = gq;
        i_dig_d = i_dig_q;
        q_dig_d = q_dig_q;
        // In sticky mode the bit present on the strobe cycle both goes out now and seeds the next interval.
        if (sticky_q && !sample_strobe) begin
            acc_i_d = acc_i_q | gi;
            acc_q_d = acc_q_q | gq;
        end
        if (sample_strobe) begin
            i_dig_d = acc_i_q | (sticky_q & gi);
            q_dig_d = acc_q_q | (sticky_q & gq);
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic        pend_q, pend_d;   // start condition met, waiting for the next strobe
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ARMED;
                    pend_d  = !wr_dat.trig_en;
                end
            end
            ST_ARMED: begin
                // A trigger edge that lands on a strobe cycle starts RUN at that strobe.
                if (sample_strobe && (pend_q || trig_rise)) begin
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                    cnt_d   = burst_q;
                end else if (trig_rise) begin
                    pend_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (sample_strobe && (burst_q != 16'd0)) begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over everything, including a coincident strobe.
        if (abort) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            gt_prev_q <= 1'b0;
            acc_i_q   <= 1'b0;
            acc_q_q   <= 1'b0;
            i_dig_q   <= 1'b0;
            q_dig_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            // On start, prime the edge detector from the newly selected pin so a level already high is not an edge.
            gt_prev_q <= start ? g_sync[wr_dat.trig_sel] : gt;
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            i_dig_q   <= i_dig_d;
            q_dig_q   <= q_dig_d;
        end
    end

    // RUN is only entered/left on strobe edges (or abort/reset), so decoding the state flop keeps samples whole.
    assign dig_enable = (state_q == ST_RUN);
    assign busy       = (state_q == ST_ARMED) || (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign i_dig      = i_dig_q;
    assign q_dig      = q_dig_q;

endmodule
